i2c_write_master: RTL and testbench
===================================

Name: i2c_write_master

Overview:
Bit-level I2C master that performs one fixed-format 3-byte write (slave address, sub-address, data) per request. It sits directly downstream of the HDMI/ADV7513 register-config sequencer, which drives it with a START/END/ACK handshake; it produces open-drain SCL/SDA toward the codec/transmitter I2C bus. Write-only: no reads, no repeated start, no clock stretching.

Parameters:
CLK_Freq, 50_000_000, CLK frequency in Hz.
I2C_Freq, 400_000, SCL frequency in Hz. Quarter-bit divider DIV = CLK_Freq/(I2C_Freq*4), integer floor, clamped to a minimum of 1.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
I2C_DATA  in  24  {slave_addr[7:0], sub_addr[7:0], data[7:0]}; slave_addr[0] is R/W and is sent as given.
START  in  1  level request; sampled only while END=1.
END  out  1  1 = idle/done, 0 = transfer in progress.
ACK  out  1  0 = all three bytes ACKed; 1 = at least one NACK in the last completed transfer.
I2C_SCL  out  1  open-drain: drives 0 or releases (z).
I2C_SDA  inout  1  open-drain: drives 0 or releases (z); sampled in ACK slots.

Behaviour:
- Reset values: END=1, ACK=0, SCL=z, SDA=z, state IDLE, divider and counters 0. A RESET mid-transfer aborts on the next edge with no STOP generated.
- Quarter tick: a counter 0..DIV-1 is restarted when the transfer starts. A tick occurs each DIV clocks and advances the quarter index q0..q3.
- Accept: in IDLE with START=1 at edge N:
  - latch I2C_DATA into a shift register;
  - clear the NACK accumulator;
  - END=0 from N+1.
  - Later changes to I2C_DATA are ignored.
- START while END=0 is ignored.
- States, each 4 quarters:
  - START_C: q0,q1 SDA=z SCL=z; q2 SDA=0; q3 SCL=0.
  - BIT (27 slots: 3 × (8 data MSB-first + 1 ACK slot)):
    - q0: SCL=0; SDA=0 if bit=0 else z; in an ACK slot SDA=z.
    - q1, q2: SCL=z.
    - q3: SCL=0.
    - In an ACK slot, SDA is sampled on the tick ending q1. A sample of 1 sets the NACK accumulator.
  - STOP_C: q0 SCL=0 SDA=0; q1 SCL=z SDA=0; q2 SCL=z SDA=z; q3 both z.
- NACK does not abort: all 3 bytes and STOP are always sent.
- Completion: at the end of STOP_C q3, END=1 and ACK=accumulator on the same edge. Total: END low for exactly 116*DIV cycles (N+1 .. N+116*DIV), END=1 at N+1+116*DIV.
- ACK holds its value until the next completion or RESET.
- Back-to-back: if START is still 1 on the cycle END returns to 1, a new transfer is accepted there. END stays 1 for exactly that one cycle.
- SDA changes only while SCL is low, except during START/STOP conditions.
- SCL is never sampled (no stretching). Bus arbitration is not supported.

Test Plan:
1. RESET=1 for 3 cycles with START=1 -> END=1, ACK=0, SCL=z, SDA=z throughout; no accept until RESET=0.
2. CLK_Freq=4_000_000, I2C_Freq=250_000 (DIV=4), I2C_DATA=24'h72_4110, slave model ACKs all, START pulse at N:
   - SDA bits sampled at SCL rise: 01110010, 01000001, 00010000 with z ACK slots;
   - START and STOP conditions correct;
   - END low N+1..N+464, END=1 at N+465, ACK=0.
3. Same transfer, slave NACKs byte 2 only -> byte 3 and STOP still emitted, END timing unchanged, ACK=1. The next transfer with all ACKs returns ACK=0.
4. Pulse START again while END=0 -> no effect on waveform or timing. Hold START=1 across completion -> END=1 for one cycle, then a second transfer starts. Drive the config-sequencer handshake (GO, wait END=0, drop GO, wait END=1) -> exactly one transfer per request.
5. Assert RESET during bit 5 of byte 2 -> next edge SCL=z, SDA=z, END=1, ACK=0. A subsequent START gives a normal full transfer.
6. Change I2C_DATA to 24'hFFFFFF one cycle after accept -> transmitted bits still match the latched 24'h72_4110.

Source files
------------

// File: rtl/i2c_write_master.sv
// Bit-level I2C write master: sends {slave_addr, sub_addr, data} as one
// START / 3 bytes + ACK slots / STOP sequence per request, open-drain outputs.
module i2c_write_master #(
    parameter int CLK_Freq = 50_000_000,
    parameter int I2C_Freq = 400_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:0] I2C_DATA,
    input  logic        START,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCL,
    inout  wire         I2C_SDA
);

    localparam int DivRaw = CLK_Freq / (I2C_Freq * 4);
    localparam int DIV    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int CntW   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START_C,
        BIT,
        STOP_C
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        quarter_q, quarter_d;
    logic [3:0]        bitIdx_q, bitIdx_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic [23:0]       shift_q, shift_d;
    logic              nack_q, nack_d;
    logic              ack_q, ack_d;
    logic              end_q, end_d;
    logic              sclLow_q, sclLow_d;
    logic              sdaLow_q, sdaLow_d;
    logic              tick;

    assign tick = (cnt_q == CntW'(DIV - 1));

    // Next-state: quarter sequencing, bit/byte slots, NACK accumulation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quarter_d = quarter_q;
        bitIdx_d  = bitIdx_q;
        byteIdx_d = byteIdx_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        ack_d     = ack_q;
        end_d     = end_q;

        if (state_q == IDLE) begin
            if (START) begin
                state_d   = START_C;
                cnt_d     = '0;
                quarter_d = 2'd0;
                bitIdx_d  = 4'd0;
                byteIdx_d = 2'd0;
                shift_d   = I2C_DATA;
                nack_d    = 1'b0;
                end_d     = 1'b0;
            end
        end else if (!tick) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d     = '0;
            quarter_d = quarter_q + 2'd1;
            case (state_q)
                START_C: begin
                    if (quarter_q == 2'd3) state_d = BIT;
                end
                BIT: begin
                    if (quarter_q == 2'd1 && bitIdx_q == 4'd8 && I2C_SDA == 1'b1)
                        nack_d = 1'b1;
                    if (quarter_q == 2'd3) begin
                        if (bitIdx_q == 4'd8) begin
                            bitIdx_d = 4'd0;
                            if (byteIdx_q == 2'd2) state_d = STOP_C;
                            else byteIdx_d = byteIdx_q + 2'd1;
                        end else begin
                            bitIdx_d = bitIdx_q + 4'd1;
                            shift_d  = {shift_q[22:0], 1'b0};
                        end
                    end
                end
                STOP_C: begin
                    if (quarter_q == 2'd3) begin
                        state_d = IDLE;
                        end_d   = 1'b1;
                        ack_d   = nack_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Line levels for the quarter being entered, so the pins are registered.
    always_comb begin
        sclLow_d = 1'b0;
        sdaLow_d = 1'b0;
        case (state_d)
            START_C: begin
                sclLow_d = (quarter_d == 2'd3);
                sdaLow_d = (quarter_d >= 2'd2);
            end
            BIT: begin
                sclLow_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sdaLow_d = (bitIdx_d != 4'd8) && !shift_d[23];
            end
            STOP_C: begin
                sclLow_d = (quarter_d == 2'd0);
                sdaLow_d = (quarter_d <= 2'd1);
            end
            default: begin
                sclLow_d = 1'b0;
                sdaLow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quarter_q <= 2'd0;
            bitIdx_q  <= 4'd0;
            byteIdx_q <= 2'd0;
            shift_q   <= 24'd0;
            nack_q    <= 1'b0;
            ack_q     <= 1'b0;
            end_q     <= 1'b1;
            sclLow_q  <= 1'b0;
            sdaLow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
            bitIdx_q  <= bitIdx_d;
            byteIdx_q <= byteIdx_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            ack_q     <= ack_d;
            end_q     <= end_d;
            sclLow_q  <= sclLow_d;
            sdaLow_q  <= sdaLow_d;
        end
    end

    assign END     = end_q;
    assign ACK     = ack_q;
    assign I2C_SCL = sclLow_q ? 1'b0 : 1'bz;
    assign I2C_SDA = sdaLow_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master: pulled-up bus, slave ACK model,
// START/STOP detection and END/ACK timing at DIV=4 (116*4 = 464 cycles low).
module tb_i2c_write_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [23:0] I2C_DATA = 24'h0;
    logic        START = 1'b0;
    logic        END;
    logic        ACK;
    wire         sclLine;
    wire         sdaLine;
    logic        slaveDrive = 1'b0;

    pullup(sclLine);
    pullup(sdaLine);
    assign sdaLine = slaveDrive ? 1'b0 : 1'bz;

    i2c_write_master #(
        .CLK_Freq(4_000_000),
        .I2C_Freq(250_000)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .I2C_DATA(I2C_DATA),
        .START(START),
        .END(END),
        .ACK(ACK),
        .I2C_SCL(sclLine),
        .I2C_SDA(sdaLine)
    );

    always #5 CLK = ~CLK;

    int passCnt = 0;
    int checkCnt = 0;

    localparam logic [27:0] BitsAllAck = {8'b01110010, 1'b0, 8'b01000001, 1'b0, 8'b00010000, 1'b0, 1'b0};
    localparam logic [27:0] BitsNack2  = {8'b01110010, 1'b0, 8'b01000001, 1'b1, 8'b00010000, 1'b0, 1'b0};

    // Bus monitor and slave: records SDA on every SCL rise, counts START/STOP
    // conditions, and pulls SDA low in the ninth clock of each byte unless told to NACK.
    logic rxQ[$];
    int   startCnt = 0;
    int   stopCnt = 0;
    int   bitCnt = 0;
    int   byteIdx = 0;
    int   nackByteSel = -1;
    logic prevScl = 1'b1;
    logic prevSda = 1'b1;

    always @(sclLine or sdaLine) begin
        if (sclLine !== prevScl) begin
            if (sclLine === 1'b1) begin
                rxQ.push_back(sdaLine);
                bitCnt++;
            end else if (sclLine === 1'b0) begin
                if (bitCnt == 8) begin
                    slaveDrive = (byteIdx != nackByteSel);
                end else if (bitCnt == 9) begin
                    slaveDrive = 1'b0;
                    bitCnt = 0;
                    byteIdx++;
                end
            end
        end else if (sclLine === 1'b1 && sdaLine !== prevSda) begin
            if (sdaLine === 1'b0) begin
                startCnt++;
                bitCnt = 0;
                byteIdx = 0;
            end else if (sdaLine === 1'b1) begin
                stopCnt++;
            end
        end
        prevScl = sclLine;
        prevSda = sdaLine;
    end

    int          lowCnt;
    int          starts;
    int          stops;
    int          nbits;
    logic [27:0] bits;

    task automatic runTransfer(input logic [23:0] data, input int nackSel, input bit holdStart,
                               input bit pulseMid, input bit corrupt);
        int base;
        int sBase;
        int pBase;
        nackByteSel = nackSel;
        base  = rxQ.size();
        sBase = startCnt;
        pBase = stopCnt;
        @(negedge CLK);
        I2C_DATA = data;
        START = 1'b1;
        @(posedge CLK);
        #1;
        if (!holdStart) START = 1'b0;
        lowCnt = 0;
        while (END === 1'b0 && lowCnt < 2000) begin
            lowCnt++;
            if (corrupt && lowCnt == 1) I2C_DATA = 24'hFFFFFF;
            if (pulseMid && lowCnt == 100) START = 1'b1;
            if (pulseMid && lowCnt == 101 && !holdStart) START = 1'b0;
            @(posedge CLK);
            #1;
        end
        starts = startCnt - sBase;
        stops  = stopCnt - pBase;
        nbits  = rxQ.size() - base;
        bits   = '0;
        for (int i = 0; i < 28 && base + i < rxQ.size(); i++) bits[27 - i] = rxQ[base + i];
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        START = 1'b1;
        I2C_DATA = 24'h724110;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            checkCnt++;
            if ({END, ACK, sclLine, sdaLine} !== 4'b1011) $display("[TB] FAIL reset_state cycle %0d: got END/ACK/SCL/SDA=%b, want 1011", c, {END, ACK, sclLine, sdaLine});
            else passCnt++;
        end
        START = 1'b0;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkCnt++;
        if (END !== 1'b1) $display("[TB] FAIL reset_no_accept: END=%b, want 1", END);
        else passCnt++;
    endtask

    task automatic test_all_ack();
        runTransfer(24'h724110, -1, 1'b0, 1'b0, 1'b0);
        checkCnt++;
        if (lowCnt !== 464) $display("[TB] FAIL all_ack_end_low: %0d cycles, want 464", lowCnt);
        else passCnt++;
        checkCnt++;
        if (bits !== BitsAllAck || nbits !== 28) $display("[TB] FAIL all_ack_bits: got %b (%0d rises), want %b (28)", bits, nbits, BitsAllAck);
        else passCnt++;
        checkCnt++;
        if (starts !== 1 || stops !== 1) $display("[TB] FAIL all_ack_start_stop: starts=%0d stops=%0d, want 1/1", starts, stops);
        else passCnt++;
        checkCnt++;
        if (ACK !== 1'b0 || sclLine !== 1'b1 || sdaLine !== 1'b1) $display("[TB] FAIL all_ack_done: ACK/SCL/SDA=%b%b%b, want 011", ACK, sclLine, sdaLine);
        else passCnt++;
    endtask

    task automatic test_nack();
        runTransfer(24'h724110, 1, 1'b0, 1'b0, 1'b0);
        checkCnt++;
        if (lowCnt !== 464) $display("[TB] FAIL nack_end_low: %0d cycles, want 464", lowCnt);
        else passCnt++;
        checkCnt++;
        if (bits !== BitsNack2 || nbits !== 28) $display("[TB] FAIL nack_bits: got %b (%0d rises), want %b (28)", bits, nbits, BitsNack2);
        else passCnt++;
        checkCnt++;
        if (stops !== 1 || ACK !== 1'b1) $display("[TB] FAIL nack_ack: stops=%0d ACK=%b, want 1/1", stops, ACK);
        else passCnt++;
        runTransfer(24'h724110, -1, 1'b0, 1'b0, 1'b0);
        checkCnt++;
        if (ACK !== 1'b0 || lowCnt !== 464) $display("[TB] FAIL nack_recover: ACK=%b low=%0d, want 0/464", ACK, lowCnt);
        else passCnt++;
    endtask

    task automatic test_start_ignored();
        runTransfer(24'h724110, -1, 1'b0, 1'b1, 1'b0);
        checkCnt++;
        if (lowCnt !== 464 || bits !== BitsAllAck || starts !== 1) $display("[TB] FAIL start_ignored: low=%0d bits=%b starts=%0d, want 464/%b/1", lowCnt, bits, starts, BitsAllAck);
        else passCnt++;
        repeat (5) @(posedge CLK);
        #1;
        checkCnt++;
        if (END !== 1'b1) $display("[TB] FAIL start_ignored_idle: END=%b, want 1", END);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        int highCnt;
        int low2;
        int sBase;
        runTransfer(24'h724110, -1, 1'b1, 1'b0, 1'b0);
        checkCnt++;
        if (lowCnt !== 464) $display("[TB] FAIL b2b_first_low: %0d cycles, want 464", lowCnt);
        else passCnt++;
        sBase = startCnt;
        highCnt = 0;
        while (END === 1'b1 && highCnt < 10) begin
            highCnt++;
            @(posedge CLK);
            #1;
        end
        checkCnt++;
        if (highCnt !== 1) $display("[TB] FAIL b2b_end_high: %0d cycles, want 1", highCnt);
        else passCnt++;
        START = 1'b0;
        low2 = 0;
        while (END === 1'b0 && low2 < 2000) begin
            low2++;
            @(posedge CLK);
            #1;
        end
        checkCnt++;
        if (low2 !== 464 || startCnt - sBase !== 1) $display("[TB] FAIL b2b_second: low=%0d starts=%0d, want 464/1", low2, startCnt - sBase);
        else passCnt++;
    endtask

    task automatic test_handshake();
        int waitCnt;
        int sBase;
        sBase = startCnt;
        nackByteSel = -1;
        I2C_DATA = 24'h724110;
        @(negedge CLK);
        START = 1'b1;
        waitCnt = 0;
        do begin
            @(posedge CLK);
            #1;
            waitCnt++;
        end while (END !== 1'b0 && waitCnt < 20);
        START = 1'b0;
        while (END !== 1'b1 && waitCnt < 2000) begin
            @(posedge CLK);
            #1;
            waitCnt++;
        end
        repeat (20) @(posedge CLK);
        #1;
        checkCnt++;
        if (END !== 1'b1 || startCnt - sBase !== 1 || waitCnt >= 2000) $display("[TB] FAIL handshake: END=%b starts=%0d cycles=%0d, want 1/1/<2000", END, startCnt - sBase, waitCnt);
        else passCnt++;
    endtask

    task automatic test_data_latch();
        runTransfer(24'h724110, -1, 1'b0, 1'b0, 1'b1);
        checkCnt++;
        if (bits !== BitsAllAck || lowCnt !== 464) $display("[TB] FAIL data_latch: bits=%b low=%0d, want %b/464", bits, lowCnt, BitsAllAck);
        else passCnt++;
    endtask

    task automatic test_mid_reset();
        int cyc;
        logic sclBefore;
        runTransfer(24'h724110, 0, 1'b0, 1'b0, 1'b0);
        checkCnt++;
        if (ACK !== 1'b1) $display("[TB] FAIL mid_reset_pre_ack: ACK=%b, want 1", ACK);
        else passCnt++;
        nackByteSel = -1;
        @(negedge CLK);
        I2C_DATA = 24'h724110;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        cyc = 1;
        while (cyc < 250) begin
            cyc++;
            @(posedge CLK);
            #1;
        end
        sclBefore = sclLine;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checkCnt++;
        if ({END, ACK, sclLine, sdaLine} !== 4'b1011 || sclBefore !== 1'b1) $display("[TB] FAIL mid_reset_abort: END/ACK/SCL/SDA=%b sclBefore=%b, want 1011/1", {END, ACK, sclLine, sdaLine}, sclBefore);
        else passCnt++;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        runTransfer(24'h724110, -1, 1'b0, 1'b0, 1'b0);
        checkCnt++;
        if (lowCnt !== 464 || bits !== BitsAllAck || starts !== 1 || stops !== 1 || ACK !== 1'b0) $display("[TB] FAIL mid_reset_recover: low=%0d bits=%b starts=%0d stops=%0d ACK=%b", lowCnt, bits, starts, stops, ACK);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_all_ack();
        test_nack();
        test_start_ignored();
        test_back_to_back();
        test_handshake();
        test_data_latch();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
